// File: rtl/param_fifo_pkg.sv
// Shared constants and width helper for the parameterised FIFO.
// Optional feature macro: PARAM_FIFO_ERR_EN (sticky overflow/underflow flags).
package param_fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_AF_MARGIN = 2;
  localparam int unsigned DEF_AE_LEVEL  = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
// Optional feature macro: PARAM_FIFO_ERR_EN adds ovf/udf.
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic             clr;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;
  logic [CW-1:0]    count;
`ifdef PARAM_FIFO_ERR_EN
  logic             ovf;
  logic             udf;

  modport master (
    output clr, wr, din, rd,
    input  dout, dout_vld, full, empty, afull, aempty, count, ovf, udf
  );

  modport slave (
    input  clr, wr, din, rd,
    output dout, dout_vld, full, empty, afull, aempty, count, ovf, udf
  );
`else
  modport master (
    output clr, wr, din, rd,
    input  dout, dout_vld, full, empty, afull, aempty, count
  );

  modport slave (
    input  clr, wr, din, rd,
    output dout, dout_vld, full, empty, afull, aempty, count
  );
`endif

endinterface

// File: rtl/param_fifo_dpram.sv
// WIDTH x DEPTH storage: one write port, one synchronous read port.
// The array itself is never reset; only the read data register is.
module fifo_dpram
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage write; no reset so contents survive rst and clr.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds its last value unless a read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointer/count control and status flags around fifo_dpram.
// Optional feature macro: PARAM_FIFO_ERR_EN enables sticky ovf/udf flags.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic          rd_acc_c;
  logic          wr_acc_c;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          dout_vld_d, dout_vld_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic          afull_d, afull_q;
  logic          aempty_d, aempty_q;

  // Accept decode, pointer/count update and flag decode of the next count.
  always_comb begin
    rd_acc_c   = bus.rd & ~empty_q & ~bus.clr;
    wr_acc_c   = bus.wr & (~full_q | rd_acc_c) & ~bus.clr;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_vld_d = rd_acc_c;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LEVEL));
    aempty_d = (count_d <= CW'(AE_LEVEL));
  end

  // Control state; flags reset to the decode of count = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_vld_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_vld_q <= dout_vld_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

`ifdef PARAM_FIFO_ERR_EN
  logic ovf_d, ovf_q;
  logic udf_d, udf_q;

  // Sticky error flags, cleared only by rst or clr.
  always_comb begin
    ovf_d = ovf_q | (bus.wr & full_q & ~bus.rd);
    udf_d = udf_q | (bus.rd & empty_q);
    if (bus.clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_c),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .re    (rd_acc_c),
    .raddr (rd_ptr_q),
    .rdata (bus.dout)
  );

  assign bus.dout_vld = dout_vld_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.afull    = afull_q;
  assign bus.aempty   = aempty_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed testbench for param_fifo (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_param_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  param_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  param_fifo #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.clr  = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    bus.din  = '0;
    #2;
    chk("rst_count",  64'(bus.count), 64'd0);
    chk("rst_empty",  64'(bus.empty), 64'd1);
    chk("rst_aempty", 64'(bus.aempty), 64'd1);
    chk("rst_full",   64'(bus.full), 64'd0);
    chk("rst_afull",  64'(bus.afull), 64'd0);
    chk("rst_dout",   64'(bus.dout), 64'd0);
    chk("rst_vld",    64'(bus.dout_vld), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Fill 0x00..0x0F, checking count and flags at every level.
    for (int i = 0; i < 16; i++) begin
      bus.wr  = 1'b1;
      bus.din = 8'(i);
      step();
      chk("fill_count",  64'(bus.count), 64'(i + 1));
      chk("fill_aempty", 64'(bus.aempty), 64'((i + 1) <= 2));
      chk("fill_afull",  64'(bus.afull), 64'((i + 1) >= 14));
      chk("fill_full",   64'(bus.full), 64'(i == 15));
      chk("fill_empty",  64'(bus.empty), 64'd0);
    end
    bus.wr = 1'b0;

    // Drain in order, one cycle of read latency.
    for (int i = 0; i < 16; i++) begin
      bus.rd = 1'b1;
      step();
      chk("drain_dout",   64'(bus.dout), 64'(i));
      chk("drain_vld",    64'(bus.dout_vld), 64'd1);
      chk("drain_count",  64'(bus.count), 64'(15 - i));
      chk("drain_aempty", 64'(bus.aempty), 64'((15 - i) <= 2));
      chk("drain_afull",  64'(bus.afull), 64'((15 - i) >= 14));
    end
    bus.rd = 1'b0;
    step();
    chk("idle_vld",   64'(bus.dout_vld), 64'd0);
    chk("idle_empty", 64'(bus.empty), 64'd1);
    chk("idle_dout",  64'(bus.dout), 64'h0F);

    // rd+wr while empty performs only the write.
    bus.rd  = 1'b1;
    bus.wr  = 1'b1;
    bus.din = 8'hA5;
    step();
    chk("rwe_count", 64'(bus.count), 64'd1);
    chk("rwe_vld",   64'(bus.dout_vld), 64'd0);
    chk("rwe_empty", 64'(bus.empty), 64'd0);
    bus.wr = 1'b0;
    step();
    chk("rwe_dout",  64'(bus.dout), 64'hA5);
    chk("rwe_vld2",  64'(bus.dout_vld), 64'd1);
    chk("rwe_count2", 64'(bus.count), 64'd0);
    step();
    chk("udfrd_vld",   64'(bus.dout_vld), 64'd0);
    chk("udfrd_dout",  64'(bus.dout), 64'hA5);
    chk("udfrd_count", 64'(bus.count), 64'd0);
`ifdef PARAM_FIFO_ERR_EN
    chk("udf_set", 64'(bus.udf), 64'd1);
    chk("ovf_clr", 64'(bus.ovf), 64'd0);
`endif
    bus.rd = 1'b0;

    // Fill, then stream rd+wr across the pointer wrap while full.
    for (int i = 0; i < 16; i++) begin
      bus.wr  = 1'b1;
      bus.din = 8'(8'h10 + i);
      step();
    end
    chk("full2_full", 64'(bus.full), 64'd1);
    bus.rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.din = 8'(8'h20 + k);
      step();
      chk("stream_dout",  64'(bus.dout), (k < 16) ? 64'(8'h10 + k) : 64'(8'h20 + k - 16));
      chk("stream_vld",   64'(bus.dout_vld), 64'd1);
      chk("stream_count", 64'(bus.count), 64'd16);
      chk("stream_full",  64'(bus.full), 64'd1);
    end

    // Write while full without read is dropped.
    bus.rd  = 1'b0;
    bus.din = 8'hFF;
    step();
    chk("wfull_count", 64'(bus.count), 64'd16);
    bus.wr = 1'b0;
    step();
`ifdef PARAM_FIFO_ERR_EN
    chk("ovf_sticky", 64'(bus.ovf), 64'd1);
`endif

    // Drain to 5 entries, then clear with a concurrent read.
    for (int i = 0; i < 11; i++) begin
      bus.rd = 1'b1;
      step();
      chk("part_dout", 64'(bus.dout), 64'(8'h24 + i));
    end
    chk("part_count", 64'(bus.count), 64'd5);
    bus.clr = 1'b1;
    step();
    chk("clr_count", 64'(bus.count), 64'd0);
    chk("clr_empty", 64'(bus.empty), 64'd1);
    chk("clr_vld",   64'(bus.dout_vld), 64'd0);
    chk("clr_dout",  64'(bus.dout), 64'h2E);
`ifdef PARAM_FIFO_ERR_EN
    chk("clr_ovf", 64'(bus.ovf), 64'd0);
    chk("clr_udf", 64'(bus.udf), 64'd0);
`endif
    bus.clr = 1'b0;
    bus.rd  = 1'b0;

    // Asynchronous reset mid-burst at count 9.
    for (int i = 0; i < 9; i++) begin
      bus.wr  = 1'b1;
      bus.din = 8'(8'h60 + i);
      step();
    end
    chk("burst_count", 64'(bus.count), 64'd9);
    bus.din = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count",  64'(bus.count), 64'd0);
    chk("arst_empty",  64'(bus.empty), 64'd1);
    chk("arst_dout",   64'(bus.dout), 64'd0);
    chk("arst_vld",    64'(bus.dout_vld), 64'd0);
    chk("arst_aempty", 64'(bus.aempty), 64'd1);
    chk("arst_full",   64'(bus.full), 64'd0);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_count", 64'(bus.count), 64'd1);
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    step();
    chk("post_rst_dout",  64'(bus.dout), 64'h77);
    chk("post_rst_vld",   64'(bus.dout_vld), 64'd1);
    chk("post_rst_count2", 64'(bus.count), 64'd0);
    bus.rd = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal range 1..64).
REQ-002 Parameter DEPTH, default 16, number of storage words (power of two, legal range 4..1024).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold in words (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold in words (1..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 clr  input  1  synchronous clear, active-high.
REQ-008 wr  input  1  write request; din is stored when the write is accepted.
REQ-009 din  input  WIDTH  write data.
REQ-010 rd  input  1  read request.
REQ-011 dout  output  WIDTH  registered read data.
REQ-012 dout_vld  output  1  one-cycle pulse; dout holds new data this cycle.
REQ-013 full, empty, afull, aempty  output  1 each  status flags.
REQ-014 count  output  CW  current occupancy; CW = clog2(DEPTH+1).
REQ-015 ovf, udf  output  1 each  sticky error flags (present only under PARAM_FIFO_ERR_EN).

Function
REQ-016 full SHALL be asserted when count==DEPTH; empty SHALL be asserted when count==0; all DEPTH words SHALL be usable.
REQ-017 afull SHALL be asserted when count>=AF_LEVEL; aempty SHALL be asserted when count<=AE_LEVEL; all flags SHALL be combinational decodes of count.
REQ-018 A write SHALL be accepted when wr=1 and (full=0, or rd=1 with the read accepted in the same cycle).
REQ-019 A read SHALL be accepted when rd=1 and empty=0; rd while empty SHALL be ignored, with dout and pointers unchanged.
REQ-020 On an accepted read, dout SHALL present mem[rd_ptr] one clock later and dout_vld SHALL pulse for that cycle; dout SHALL otherwise hold its last value.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged and advance both pointers.
REQ-022 rd=1 and wr=1 while empty SHALL perform the write only; count SHALL go 0->1 and dout_vld SHALL stay 0.
REQ-023 rd=1 and wr=1 while full SHALL perform both; count SHALL remain DEPTH.
REQ-024 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-025 count SHALL increment on a write-only, decrement on a read-only, and never leave 0..DEPTH.
REQ-026 clr SHALL take priority over rd/wr: pointers and count SHALL go to 0 and dout_vld to 0; dout and memory contents SHALL be unchanged.

Reset
REQ-027 rst=1 SHALL immediately force pointers=0, count=0, dout=0, dout_vld=0, ovf=0, udf=0; empty=1, aempty=1, full=0, afull=0.
REQ-028 Storage memory SHALL NOT be reset; an operation in flight when rst asserts SHALL be discarded.
REQ-029 The first accepted operation SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-030 With macro PARAM_FIFO_ERR_EN defined, ovf SHALL set on wr=1 with full=1 and rd=0, udf SHALL set on rd=1 with empty=1; both SHALL clear only on rst or clr.
REQ-031 Without PARAM_FIFO_ERR_EN, ports ovf and udf and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package param_fifo_pkg SHALL hold the clog2 width function and the default threshold constants.
REQ-033 Storage SHALL be a sub-module fifo_dpram (one write port, one synchronous read port, WIDTH x DEPTH); control, flags and count SHALL live in param_fifo.

Verification (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-034 Write 0x00..0x0F, then read 16 times -> full=1 after the 16th write; dout = 0x00..0x0F in order, each one cycle after rd; empty=1 at the end.
REQ-035 Fill to 16, hold rd=wr=1 for 20 cycles -> count stays 16, full stays 1, data order is preserved across pointer wrap.
REQ-036 From empty, pulse rd=wr=1 with din=0xA5 -> count=1, dout_vld=0; next read returns 0xA5.
REQ-037 Step count 0..16 -> aempty=1 for count<=2; afull=1 for count>=14.
REQ-038 Assert rst asynchronously mid-burst at count=9 -> count=0, dout=0, empty=1 before the next edge; clr at count=5 -> count=0 next cycle, dout unchanged.
REQ-039 With PARAM_FIFO_ERR_EN: write while full -> ovf=1 sticky; read while empty -> udf=1; clr -> both return to 0.
